mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the CPU's single-ported unified memory between instruction fetch (IF)
//   and load/store (D) requesters. Text lives at low words, data at word 2048+.
//   Holds one access in flight, arbitrates round-robin on contention, and returns
//   read data or a write acknowledge. The CPU stalls on busy/no-grant.
// PARAMETERS
//   MEM_AW       12  word-address width of the memory (4096 words)
//   MEM_LATENCY  1   cycles from mem_en issue to mem_rdata valid (>=1)
// PORTS
//   clk        in   1        rising-edge clock
//   reset      in   1        synchronous, active-high
//   if_req     in   1        fetch request; held with if_addr until if_gnt
//   if_addr    in   32       fetch byte address
//   if_gnt     out  1        fetch accepted this cycle
//   if_rvalid  out  1        one-cycle pulse: if_rdata valid
//   if_rdata   out  32       fetched instruction
//   d_req      in   1        data request; held with d_we/d_addr/d_wdata until d_gnt
//   d_we       in   1        1 = store, 0 = load
//   d_addr     in   32       data byte address
//   d_wdata    in   32       store data
//   d_gnt      out  1        data access accepted this cycle
//   d_rvalid   out  1        one-cycle pulse: load data valid / store complete
//   d_rdata    out  32       load data (0 for store completions)
//   mem_en     out  1        memory access strobe, one cycle per access
//   mem_we     out  1        memory write enable (qualified by mem_en)
//   mem_addr   out  MEM_AW   word address = addr[MEM_AW+1:2]
//   mem_wdata  out  32       write data
//   mem_rdata  in   32       memory read data, valid MEM_LATENCY cycles after issue
//   busy       out  1        1 whenever state != IDLE
// BEHAVIOUR
//   - Reset: state=IDLE, last_winner=D, all outputs 0, captured cmd cleared.
//   - FSM: IDLE -> ISSUE -> WAIT -> RESP -> (IDLE | ISSUE).
//     IDLE/RESP: arbitration cycle; if any req, assert that requester's gnt
//       (combinational from req+state) and register addr/we/wdata/owner -> ISSUE.
//     ISSUE: mem_en=1, mem_we=cmd_we, mem_addr/mem_wdata from the captured command;
//       load latency counter with MEM_LATENCY -> WAIT.
//     WAIT: decrement; at 0 register mem_rdata (loads) -> RESP.
//     RESP: owner's rvalid=1 for exactly one cycle; re-arbitrate in same cycle.
//   - Timing (MEM_LATENCY=1): gnt T, mem_en T+1, rdata sampled T+2, rvalid T+3,
//     next gnt may also be T+3. One access per MEM_LATENCY+2 cycles.
//   - Arbitration: single requester always wins. Both requesting: grant the one
//     != last_winner; update last_winner on every grant. First contention after
//     reset goes to IF.
//   - Exactly one gnt per cycle at most; gnt never asserted in ISSUE/WAIT.
//   - Requests arriving during ISSUE/WAIT wait; no request is dropped or queued
//     beyond the held req line.
//   - Address: addr[1:0] ignored (word access); bits above MEM_AW+1 ignored (wraps).
//   - Store: d_rvalid pulses in RESP, d_rdata=0; mem_rdata is not sampled.
//   - if_rdata/d_rdata hold their last value between rvalid pulses.
//   - reset mid-access: next cycle IDLE, mem_en=0, in-flight access is discarded,
//     no rvalid issued; a write already issued in ISSUE is not undone.
//   - req deassert after gnt has no effect on the accepted access.
// STRUCTURE
//   - mem_arb_pkg: state encoding (IDLE, ISSUE, WAIT, RESP), owner IDs
//     (OWN_IF=0, OWN_D=1), data-width constant 32.
//   - Sub-module mem_lat_counter: load/decrement/zero-flag latency counter,
//     width $clog2(MEM_LATENCY+1).
//   - Top: FSM, round-robin pointer, command capture registers, response regs.
// TESTING
//   1 reset held 3 cycles with if_req=1 -> no gnt, mem_en=0, busy=0; IF gnt
//     in first cycle after reset release.
//   2 IF only, mem[0]=0x20050078, if_addr=0 -> if_gnt T, mem_en/mem_addr=0 at T+1,
//     if_rvalid at T+3 with if_rdata=0x20050078.
//   3 store d_addr=0x2000 d_wdata=365, then load same address -> mem_we=1,
//     mem_addr=0x800; load returns d_rdata=365; store ack d_rdata=0.
//   4 IF and D held continuously for 6 grants -> grants alternate IF,D,IF,D,...
//     starting with IF; never two gnts in one cycle.
//   5 MEM_LATENCY=3 build: gnt T, mem_en T+1, rvalid T+5; busy high T+1..T+5.
//   6 reset asserted during WAIT of a load -> IDLE next cycle, no d_rvalid,
//     next request granted normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Package for the memory port arbiter.
// Contents:
//   - arbiter FSM state encoding
//   - requester owner IDs
//   - data width
//   - round-robin winner selection helper
package mem_arb_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  // A lone requester always wins. On contention, the requester that did not
  // win last time is picked.
  function automatic owner_e pick_owner(input logic   if_req,
                                        input logic   d_req,
                                        input owner_e last);
    owner_e win;
    if (if_req && d_req) begin
      win = (last == OWN_IF) ? OWN_D : OWN_IF;
    end else if (d_req) begin
      win = OWN_D;
    end else begin
      win = OWN_IF;
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Latency counter for the memory port arbiter.
// Behaviour:
//   - Loaded with MEM_LATENCY while a command is issued.
//   - Decremented while the arbiter waits for read data.
//   - zero_next flags that the current decrement takes the count to zero,
//     i.e. mem_rdata is valid this cycle.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   load        reload the counter with MEM_LATENCY
//   dec         count down by one
//   zero_next   the count is 1, so this decrement reaches zero
module mem_lat_counter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero_next
);

  localparam int CW = $clog2(MEM_LATENCY + 1);

  logic [CW-1:0] cnt_r;

  // Count register: reset to zero, reload on issue, count down while waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= CW'(0);
    end else if (load) begin
      cnt_r <= CW'(MEM_LATENCY);
    end else if (dec && (cnt_r != CW'(0))) begin
      cnt_r <= cnt_r - CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero_next = (cnt_r == CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter that shares a single-ported memory between instruction fetch (IF)
// and load/store (D) requesters.
// Behaviour:
//   - One access is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP.
//   - IDLE and RESP are arbitration cycles, with round-robin on contention.
// Ports:
//   if_req/if_addr                     fetch request, held until if_gnt
//   if_gnt, if_rvalid, if_rdata        fetch grant and response
//   d_req/d_we/d_addr/d_wdata          load/store request, held until d_gnt
//   d_gnt, d_rvalid, d_rdata           data grant and response (0 for stores)
//   mem_en/mem_we/mem_addr/mem_wdata   memory command, one strobe per access
//   mem_rdata                          memory read data, MEM_LATENCY after issue
//   busy                               an access is in progress
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_AW      = 12,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  arb_state_e              state_r;
  arb_state_e              state_s;
  owner_e                  last_winner_r;
  owner_e                  win_s;
  owner_e                  cmd_owner_r;
  logic                    cmd_we_r;
  logic [MEM_AW-1:0]       cmd_addr_r;
  logic [DATA_W-1:0]       cmd_wdata_r;
  logic                    mem_en_r;
  logic                    mem_we_r;
  logic                    if_rvalid_r;
  logic [DATA_W-1:0]       if_rdata_r;
  logic                    d_rvalid_r;
  logic [DATA_W-1:0]       d_rdata_r;
  logic                    arb_cycle_s;
  logic                    grant_s;
  logic                    lat_done_s;
  logic [31:0]             sel_addr_s;
  logic                    addr_unused_s;

  // Byte offset and bits above the memory size are dropped (word access, wraps).
  assign addr_unused_s = ^{if_addr[31:MEM_AW+2], if_addr[1:0],
                           d_addr[31:MEM_AW+2], d_addr[1:0]};

  // Grants are combinational so the requester sees acceptance in the same cycle.
  assign arb_cycle_s = !reset && ((state_r == ST_IDLE) || (state_r == ST_RESP));
  assign grant_s     = arb_cycle_s && (if_req || d_req);
  assign win_s       = pick_owner(if_req, d_req, last_winner_r);
  assign if_gnt      = grant_s && (win_s == OWN_IF);
  assign d_gnt       = grant_s && (win_s == OWN_D);
  assign sel_addr_s  = (win_s == OWN_D) ? d_addr : if_addr;

  mem_lat_counter #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (state_r == ST_ISSUE),
    .dec      (state_r == ST_WAIT),
    .zero_next(lat_done_s)
  );

  // Next-state logic for the access sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  state_s = grant_s ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_s = ST_WAIT;
      ST_WAIT:  state_s = lat_done_s ? ST_RESP : ST_WAIT;
      ST_RESP:  state_s = grant_s ? ST_ISSUE : ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State register and round-robin pointer (D counts as last winner after reset).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      last_winner_r <= OWN_D;
    end else begin
      state_r       <= state_s;
      last_winner_r <= grant_s ? win_s : last_winner_r;
    end
  end

  // Command capture at grant; the memory strobe is high in the following (ISSUE) cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_owner_r <= OWN_IF;
      cmd_we_r    <= 1'b0;
      cmd_addr_r  <= '0;
      cmd_wdata_r <= 32'd0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
    end else if (grant_s) begin
      cmd_owner_r <= win_s;
      cmd_we_r    <= (win_s == OWN_D) && d_we;
      cmd_addr_r  <= sel_addr_s[MEM_AW+1:2];
      cmd_wdata_r <= d_wdata;
      mem_en_r    <= 1'b1;
      mem_we_r    <= (win_s == OWN_D) && d_we;
    end else begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
    end
  end

  // Response registers: one-cycle rvalid in RESP; read data holds between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
      if_rdata_r  <= 32'd0;
      d_rdata_r   <= 32'd0;
    end else if ((state_r == ST_WAIT) && lat_done_s) begin
      if_rvalid_r <= (cmd_owner_r == OWN_IF);
      d_rvalid_r  <= (cmd_owner_r == OWN_D);
      if (cmd_owner_r == OWN_IF) begin
        if_rdata_r <= mem_rdata;
      end else begin
        d_rdata_r  <= cmd_we_r ? 32'd0 : mem_rdata;
      end
    end else begin
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
    end
  end

  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = cmd_addr_r;
  assign mem_wdata = cmd_wdata_r;
  assign if_rvalid = if_rvalid_r;
  assign if_rdata  = if_rdata_r;
  assign d_rvalid  = d_rvalid_r;
  assign d_rdata   = d_rdata_r;
  assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a cycle-schedule model for the
// MEM_LATENCY=1 instance plus directed literal checks, and a MEM_LATENCY=3
// instance for latency timing.
module tb_mem_port_arbiter;

  localparam int LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        if_req, if_gnt, if_rvalid, d_req, d_we, d_gnt, d_rvalid;
  logic        mem_en, mem_we, busy;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic [11:0] mem_addr;

  logic        if_req3, if_gnt3, if_rvalid3, d_req3, d_we3, d_gnt3, d_rvalid3;
  logic        mem_en3, mem_we3, busy3;
  logic [31:0] if_addr3, if_rdata3, d_addr3, d_wdata3, d_rdata3, mem_wdata3, mem_rdata3;
  logic [11:0] mem_addr3;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(.MEM_AW(12), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.MEM_AW(12), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3), .d_gnt(d_gnt3),
    .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'h2005_0078;
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0003);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory behind the latency-1 instance; read data is garbage except when valid.
  logic [31:0] mem1 [0:4095];
  logic        pv1;
  logic [31:0] pd1;
  assign mem_rdata = (pv1 === 1'b1) ? pd1 : 32'hDEAD_BEEF;
  initial begin
    for (int i = 0; i < 4096; i++) mem1[i] = init_word(i);
    pv1 = 1'b0;
    pd1 = 32'd0;
    forever begin
      @(posedge clk);
      if (mem_en === 1'b1 && mem_we === 1'b1) mem1[mem_addr] <= mem_wdata;
      pv1 <= (mem_en === 1'b1) && (mem_we !== 1'b1);
      pd1 <= mem1[mem_addr];
    end
  end

  // Memory behind the latency-3 instance.
  logic [31:0] mem3 [0:4095];
  logic [2:0]  pv3;
  logic [31:0] pd3 [0:2];
  assign mem_rdata3 = (pv3[2] === 1'b1) ? pd3[2] : 32'hDEAD_BEEF;
  initial begin
    for (int i = 0; i < 4096; i++) mem3[i] = init_word(i);
    pv3 = 3'd0;
    forever begin
      @(posedge clk);
      if (mem_en3 === 1'b1 && mem_we3 === 1'b1) mem3[mem_addr3] <= mem_wdata3;
      pv3    <= {pv3[1:0], (mem_en3 === 1'b1) && (mem_we3 !== 1'b1)};
      pd3[0] <= mem3[mem_addr3];
      pd3[1] <= pd3[0];
      pd3[2] <= pd3[1];
    end
  end

  // Model: grant at cycle t implies strobe at t+1, response at t+LAT+2, busy over
  // t+1..t+LAT+2, and no new grant before t+LAT+2.
  logic [31:0] ref_mem [0:4095];
  bit          e_en [0:63];
  bit          e_we [0:63];
  bit          e_rvi [0:63];
  bit          e_rvd [0:63];
  logic [11:0] e_addr [0:63];
  logic [31:0] e_wd [0:63];
  logic [31:0] e_rd [0:63];

  initial begin
    int cyc, next_free, last_grant, slot, s1, s2;
    bit armed, lw_d, g_if, g_d, exp_busy;
    logic [31:0] hold_if, hold_d, a;
    logic [11:0] wa;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
    for (int i = 0; i < 64; i++) begin
      e_en[i] = 0; e_we[i] = 0; e_rvi[i] = 0; e_rvd[i] = 0;
    end
    cyc = 0; next_free = 0; last_grant = -100; armed = 0; lw_d = 1;
    hold_if = 32'd0; hold_d = 32'd0;
    forever begin
      @(negedge clk);
      slot = cyc % 64;
      g_if = 0;
      g_d  = 0;
      if (reset !== 1'b1 && armed && cyc >= next_free) begin
        if (if_req && d_req) begin
          if (lw_d) g_if = 1; else g_d = 1;
        end else if (if_req) g_if = 1;
        else if (d_req) g_d = 1;
      end
      if (armed) begin
        if (e_rvi[slot]) hold_if = e_rd[slot];
        if (e_rvd[slot]) hold_d = e_rd[slot];
        exp_busy = (cyc >= last_grant + 1) && (cyc <= last_grant + LAT + 2);
        chk("if_gnt", {31'd0, if_gnt}, {31'd0, g_if});
        chk("d_gnt", {31'd0, d_gnt}, {31'd0, g_d});
        chk("mem_en", {31'd0, mem_en}, {31'd0, e_en[slot]});
        if (e_en[slot]) begin
          chk("mem_we", {31'd0, mem_we}, {31'd0, e_we[slot]});
          chk("mem_addr", {20'd0, mem_addr}, {20'd0, e_addr[slot]});
          if (e_we[slot]) chk("mem_wdata", mem_wdata, e_wd[slot]);
        end
        chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, e_rvi[slot]});
        chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, e_rvd[slot]});
        chk("if_rdata", if_rdata, hold_if);
        chk("d_rdata", d_rdata, hold_d);
        chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      end
      e_en[slot] = 0; e_we[slot] = 0; e_rvi[slot] = 0; e_rvd[slot] = 0;
      if (reset === 1'b1) begin
        for (int i = 0; i < 64; i++) begin
          e_en[i] = 0; e_we[i] = 0; e_rvi[i] = 0; e_rvd[i] = 0;
        end
        armed = 1; lw_d = 1; next_free = cyc + 1; last_grant = -100;
        hold_if = 32'd0; hold_d = 32'd0;
      end else if (g_if || g_d) begin
        a  = g_d ? d_addr : if_addr;
        wa = a[13:2];
        s1 = (cyc + 1) % 64;
        s2 = (cyc + LAT + 2) % 64;
        lw_d = g_d;
        last_grant = cyc;
        next_free = cyc + LAT + 2;
        e_en[s1] = 1;
        e_we[s1] = g_d && d_we;
        e_addr[s1] = wa;
        e_wd[s1] = d_wdata;
        if (g_d && d_we) ref_mem[wa] = d_wdata;
        e_rvi[s2] = g_if;
        e_rvd[s2] = g_d;
        e_rd[s2] = (g_d && d_we) ? 32'd0 : ref_mem[wa];
      end
      cyc++;
    end
  end

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: no grant within cycle budget", name);
  endtask

  task automatic if_access(input logic [31:0] addr, output logic s_en, output logic [11:0] s_addr,
                           output logic s_rv, output logic [31:0] s_rd);
    bit got;
    got = 0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = addr;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (if_gnt === 1'b1) got = 1;
    end
    if (!got) timeout_fail("if_access");
    @(posedge clk); #1;
    if_req = 1'b0; if_addr = 32'hFFFF_FFFC;
    @(negedge clk);
    s_en = mem_en; s_addr = mem_addr;
    @(negedge clk);
    @(negedge clk);
    s_rv = if_rvalid; s_rd = if_rdata;
  endtask

  task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic s_we, output logic [11:0] s_addr,
                          output logic s_rv, output logic [31:0] s_rd);
    bit got;
    got = 0;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (d_gnt === 1'b1) got = 1;
    end
    if (!got) timeout_fail("d_access");
    @(posedge clk); #1;
    d_req = 1'b0; d_we = ~we; d_addr = 32'hFFFF_FFFC; d_wdata = 32'hBAD0_BAD0;
    @(negedge clk);
    s_we = mem_we; s_addr = mem_addr;
    @(negedge clk);
    @(negedge clk);
    s_rv = d_rvalid; s_rd = d_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        s_en, s_we, s_rv;
    logic [11:0] s_addr;
    logic [31:0] s_rd;
    int          order [0:5];
    int          n_g;
    bit          got;
    int          exp_order [0:5];
    exp_order = '{0, 1, 0, 1, 0, 1};

    reset = 1'b1;
    if_req = 1'b1; if_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    if_req3 = 1'b0; if_addr3 = 32'd0;
    d_req3 = 1'b0; d_we3 = 1'b0; d_addr3 = 32'd0; d_wdata3 = 32'd0;

    // Test 1: reset held with a pending fetch.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
      chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_if_gnt", {31'd0, if_gnt}, 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
    repeat (4) @(negedge clk);

    // Test 2: single fetch from word 0.
    if_access(32'd0, s_en, s_addr, s_rv, s_rd);
    chk("t2_mem_en", {31'd0, s_en}, 32'd1);
    chk("t2_mem_addr", {20'd0, s_addr}, 32'd0);
    chk("t2_if_rvalid", {31'd0, s_rv}, 32'd1);
    chk("t2_if_rdata", s_rd, 32'h2005_0078);

    // Address wrap and byte-offset drop: 0x10006 maps to word 1.
    if_access(32'h0001_0006, s_en, s_addr, s_rv, s_rd);
    chk("wrap_mem_addr", {20'd0, s_addr}, 32'd1);
    chk("wrap_if_rdata", s_rd, init_word(1));

    // Test 3: store then load of the same address.
    d_access(1'b1, 32'h0000_2000, 32'd365, s_we, s_addr, s_rv, s_rd);
    chk("t3_st_mem_we", {31'd0, s_we}, 32'd1);
    chk("t3_st_mem_addr", {20'd0, s_addr}, 32'h800);
    chk("t3_st_rvalid", {31'd0, s_rv}, 32'd1);
    chk("t3_st_rdata", s_rd, 32'd0);
    d_access(1'b0, 32'h0000_2000, 32'd0, s_we, s_addr, s_rv, s_rd);
    chk("t3_ld_mem_we", {31'd0, s_we}, 32'd0);
    chk("t3_ld_rdata", s_rd, 32'd365);
    d_access(1'b0, 32'h8000_2003, 32'd0, s_we, s_addr, s_rv, s_rd);
    chk("t3_wrap_ld_rdata", s_rd, 32'd365);

    // Test 4: continuous contention right after reset.
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    if_req = 1'b1; if_addr = 32'h0000_0004;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000;
    n_g = 0;
    for (int k = 0; k < 40 && n_g < 6; k++) begin
      @(negedge clk);
      if (if_gnt === 1'b1) begin order[n_g] = 0; n_g++; end
      else if (d_gnt === 1'b1) begin order[n_g] = 1; n_g++; end
    end
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    if (n_g < 6) timeout_fail("t4_grants");
    for (int k = 0; k < n_g; k++) chk("t4_grant_order", order[k], exp_order[k]);
    repeat (4) @(negedge clk);

    // Test 6: reset during WAIT of a load discards the access.
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2004;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (d_gnt === 1'b1) got = 1;
    end
    if (!got) timeout_fail("t6_d_gnt");
    @(posedge clk); #1; d_req = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("t6_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_mem_en", {31'd0, mem_en}, 32'd0);
    if_access(32'h0000_0008, s_en, s_addr, s_rv, s_rd);
    chk("t6_next_rvalid", {31'd0, s_rv}, 32'd1);
    chk("t6_next_rdata", s_rd, init_word(2));

    // Test 5: MEM_LATENCY=3 instance timing.
    @(posedge clk); #1;
    if_req3 = 1'b1; if_addr3 = 32'h0000_000C;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (if_gnt3 === 1'b1) got = 1;
    end
    if (!got) timeout_fail("t5_if_gnt");
    @(posedge clk); #1; if_req3 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      else @(negedge clk);
      chk("t5_mem_en", {31'd0, mem_en3}, {31'd0, (k == 1)});
      chk("t5_busy", {31'd0, busy3}, {31'd0, (k <= 5)});
      chk("t5_if_rvalid", {31'd0, if_rvalid3}, {31'd0, (k == 5)});
      if (k == 5) chk("t5_if_rdata", if_rdata3, init_word(3));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
